// File: rtl/tag_rx_pkg.sv
// Constants and state encoding shared by the tag RX sync generator and the symbol synchroniser.
package tag_rx_pkg;

  localparam int unsigned SYNC_AMP    = 16384;
  localparam int unsigned SYNC_LEN    = 8000;
  localparam int unsigned SYNC_MIN    = 7900;
  localparam int unsigned SYNC_THRESH = 8192;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POS  = 2'd1,
    ST_NEG  = 2'd2,
    ST_ACQ  = 2'd3
  } sync_state_e;

endpackage

// File: rtl/tag_iq_integrator.sv
// Dual I/Q integrate-and-dump; sums are registered and held until the next dump.
module tag_iq_integrator
  import tag_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 40
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_clear,
  input  logic                  i_start,
  input  logic                  i_valid,
  input  logic                  i_dump,
  input  logic [DATA_WIDTH-1:0] i_sample_i,
  input  logic [DATA_WIDTH-1:0] i_sample_q,
  output logic [ACC_WIDTH-1:0]  o_sum_i,
  output logic [ACC_WIDTH-1:0]  o_sum_q,
  output logic                  o_dump_valid
);

  logic [ACC_WIDTH-1:0] r_acc_i;
  logic [ACC_WIDTH-1:0] r_acc_q;
  logic [ACC_WIDTH-1:0] r_sum_i;
  logic [ACC_WIDTH-1:0] r_sum_q;
  logic                 r_dump_valid;
  logic [ACC_WIDTH-1:0] w_ext_i;
  logic [ACC_WIDTH-1:0] w_ext_q;

  assign w_ext_i = {{(ACC_WIDTH-DATA_WIDTH){i_sample_i[DATA_WIDTH-1]}}, i_sample_i};
  assign w_ext_q = {{(ACC_WIDTH-DATA_WIDTH){i_sample_q[DATA_WIDTH-1]}}, i_sample_q};

  // Accumulate valid samples; on dump publish acc+sample and restart from zero.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_acc_i      <= '0;
      r_acc_q      <= '0;
      r_sum_i      <= '0;
      r_sum_q      <= '0;
      r_dump_valid <= 1'b0;
    end else begin
      r_dump_valid <= 1'b0;
      if (i_start) begin
        r_acc_i <= '0;
        r_acc_q <= '0;
      end else if (i_valid) begin
        if (i_dump) begin
          r_sum_i      <= r_acc_i + w_ext_i;
          r_sum_q      <= r_acc_q + w_ext_q;
          r_acc_i      <= '0;
          r_acc_q      <= '0;
          r_dump_valid <= 1'b1;
        end else begin
          r_acc_i <= r_acc_i + w_ext_i;
          r_acc_q <= r_acc_q + w_ext_q;
        end
      end
    end
  end

  assign o_sum_i      = r_sum_i;
  assign o_sum_q      = r_sum_q;
  assign o_dump_valid = r_dump_valid;

endmodule

// File: rtl/tag_rx_symb_sync.sv
// Preamble detector plus per-symbol integrate-and-dump with a valid/ready result stream.
module tag_rx_symb_sync #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ACC_WIDTH   = 40,
  parameter int unsigned CNT_WIDTH   = 24,
  parameter int unsigned NSYMB_WIDTH = 16,
  parameter int unsigned NSYMB       = 64,
  parameter int unsigned SYMB_LEN    = 5120,
  parameter int unsigned SYNC_LEN    = tag_rx_pkg::SYNC_LEN,
  parameter int unsigned SYNC_MIN    = tag_rx_pkg::SYNC_MIN,
  parameter int unsigned SYNC_THRESH = tag_rx_pkg::SYNC_THRESH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  irx_in,
  input  logic [DATA_WIDTH-1:0]  qrx_in,
  output logic                   out_tvalid,
  input  logic                   out_tready,
  output logic                   out_tlast,
  output logic [ACC_WIDTH-1:0]   out_i,
  output logic [ACC_WIDTH-1:0]   out_q,
  output logic [NSYMB_WIDTH-1:0] out_symb,
  output logic                   sync_locked,
  output logic                   sync_err,
  output logic                   frame_done,
  output logic                   overflow,
  output logic [1:0]             state
);

  import tag_rx_pkg::*;

  localparam logic signed [DATA_WIDTH-1:0] L_THR_P     = DATA_WIDTH'(SYNC_THRESH);
  localparam logic signed [DATA_WIDTH-1:0] L_THR_N     = -L_THR_P;
  localparam logic [CNT_WIDTH-1:0]         L_RUN_MIN   = CNT_WIDTH'(SYNC_MIN);
  localparam logic [CNT_WIDTH-1:0]         L_RUN_MAX   = CNT_WIDTH'(SYNC_LEN);
  localparam logic [CNT_WIDTH-1:0]         L_RUN_SAT   = CNT_WIDTH'(SYNC_LEN + 1);
  localparam logic [CNT_WIDTH-1:0]         L_NEG_LAST  = CNT_WIDTH'(SYNC_LEN - 1);
  localparam logic [CNT_WIDTH-1:0]         L_SAMP_LAST = CNT_WIDTH'(SYMB_LEN - 1);
  localparam logic [NSYMB_WIDTH-1:0]       L_SYMB_LAST = NSYMB_WIDTH'(NSYMB - 1);

  sync_state_e            r_state;
  logic [CNT_WIDTH-1:0]   r_run;
  logic [CNT_WIDTH-1:0]   r_samp_cnt;
  logic [NSYMB_WIDTH-1:0] r_symb;
  logic [NSYMB_WIDTH-1:0] r_out_symb;
  logic                   r_tvalid;
  logic                   r_tlast;
  logic                   r_locked;
  logic                   r_sync_err;
  logic                   r_frame_done;
  logic                   r_overflow;

  logic w_pos;
  logic w_neg;
  logic w_acq_valid;
  logic w_dump;
  logic w_start;
  logic w_last_symb;
  logic w_int_dump_valid;

  assign w_pos       = $signed(irx_in) >= L_THR_P;
  assign w_neg       = $signed(irx_in) <= L_THR_N;
  assign w_acq_valid = in_valid && (r_state == ST_ACQ);
  assign w_dump      = w_acq_valid && (r_samp_cnt == L_SAMP_LAST);
  assign w_start     = in_valid && (r_state == ST_NEG) && w_neg && (r_run == L_NEG_LAST);
  assign w_last_symb = (r_symb == L_SYMB_LAST);

  // Symbol sums; the integrator's registered dump outputs drive out_i/out_q directly.
  tag_iq_integrator #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_integrator (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (clear),
    .i_start      (w_start),
    .i_valid      (w_acq_valid),
    .i_dump       (w_dump),
    .i_sample_i   (irx_in),
    .i_sample_q   (qrx_in),
    .o_sum_i      (out_i),
    .o_sum_q      (out_q),
    .o_dump_valid (w_int_dump_valid)
  );

  // Sync FSM, sample/symbol counters and result handshake; clear outranks all events.
  // A fresh result is published on the same edge the integrator dumps, so its
  // delayed dump strobe is redundant here and only absorbed by the default arm.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_state      <= ST_IDLE;
      r_run        <= '0;
      r_samp_cnt   <= '0;
      r_symb       <= '0;
      r_out_symb   <= '0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
      r_locked     <= 1'b0;
      r_sync_err   <= 1'b0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_sync_err   <= 1'b0;
      r_frame_done <= 1'b0;

      if (w_dump) begin
        r_tvalid   <= 1'b1;
        r_out_symb <= r_symb;
        r_tlast    <= w_last_symb;
        if (r_tvalid && !out_tready) begin
          r_overflow <= 1'b1;
        end
      end else if (r_tvalid && out_tready) begin
        r_tvalid <= 1'b0;
      end

      if (in_valid) begin
        case (r_state)
          ST_IDLE: begin
            if (w_pos) begin
              r_state <= ST_POS;
              r_run   <= CNT_WIDTH'(1);
            end
          end
          ST_POS: begin
            if (w_pos) begin
              if (r_run != L_RUN_SAT) begin
                r_run <= r_run + CNT_WIDTH'(1);
              end
            end else if (w_neg && (r_run >= L_RUN_MIN) && (r_run <= L_RUN_MAX)) begin
              r_state <= ST_NEG;
              r_run   <= CNT_WIDTH'(1);
            end else begin
              r_sync_err <= 1'b1;
              r_state    <= ST_IDLE;
              r_run      <= '0;
            end
          end
          ST_NEG: begin
            if (w_neg) begin
              if (r_run == L_NEG_LAST) begin
                r_state    <= ST_ACQ;
                r_locked   <= 1'b1;
                r_run      <= '0;
                r_samp_cnt <= '0;
                r_symb     <= '0;
              end else begin
                r_run <= r_run + CNT_WIDTH'(1);
              end
            end else begin
              r_sync_err <= 1'b1;
              r_state    <= ST_IDLE;
              r_run      <= '0;
            end
          end
          ST_ACQ: begin
            if (w_dump) begin
              r_samp_cnt <= '0;
              if (w_last_symb) begin
                r_frame_done <= 1'b1;
                r_locked     <= 1'b0;
                r_state      <= ST_IDLE;
                r_symb       <= '0;
              end else begin
                r_symb <= r_symb + NSYMB_WIDTH'(1);
              end
            end else begin
              r_samp_cnt <= r_samp_cnt + CNT_WIDTH'(1);
            end
          end
          default: begin
            r_state <= w_int_dump_valid ? ST_IDLE : ST_IDLE;
          end
        endcase
      end
    end
  end

  assign out_tvalid  = r_tvalid;
  assign out_tlast   = r_tlast;
  assign out_symb    = r_out_symb;
  assign sync_locked = r_locked;
  assign sync_err    = r_sync_err;
  assign frame_done  = r_frame_done;
  assign overflow    = r_overflow;
  assign state       = r_state;

endmodule

// File: tb/tb_tag_rx_symb_sync.sv
// Directed bench for tag_rx_symb_sync with reduced frame parameters.
module tb_tag_rx_symb_sync;

  localparam int DW = 16;
  localparam int AW = 40;

  logic          clk = 1'b0;
  logic          reset, clear, in_valid, out_tready;
  logic [DW-1:0] irx_in, qrx_in;
  logic          out_tvalid, out_tlast, sync_locked, sync_err, frame_done, overflow;
  logic [AW-1:0] out_i, out_q;
  logic [15:0]   out_symb;
  logic [1:0]    state;

  tag_rx_symb_sync #(
    .DATA_WIDTH(16), .ACC_WIDTH(40), .CNT_WIDTH(24), .NSYMB_WIDTH(16),
    .NSYMB(3), .SYMB_LEN(4), .SYNC_LEN(16), .SYNC_MIN(12), .SYNC_THRESH(8192)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
    .irx_in(irx_in), .qrx_in(qrx_in), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .out_tlast(out_tlast), .out_i(out_i), .out_q(out_q), .out_symb(out_symb),
    .sync_locked(sync_locked), .sync_err(sync_err), .frame_done(frame_done),
    .overflow(overflow), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint i;
    longint q;
    int     symb;
    int     last;
  } res_t;

  typedef struct {
    int np;
    int nn;
    int tail;
    int tail_i;
    int exp_state;
    int exp_lock;
    int exp_err;
  } sync_vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   err_cnt = 0;
  int   fd_cnt = 0;
  res_t got[$];

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // One clock: log accepted results before the edge, pulse outputs after it.
  task automatic tick();
    res_t r;
    if (out_tvalid && out_tready) begin
      r.i    = longint'($signed(out_i));
      r.q    = longint'($signed(out_q));
      r.symb = int'(out_symb);
      r.last = int'(out_tlast);
      got.push_back(r);
    end
    @(posedge clk);
    #1;
    if (sync_err)   err_cnt++;
    if (frame_done) fd_cnt++;
  endtask

  task automatic smp(input bit v, input int i, input int q);
    in_valid = v;
    irx_in   = DW'(i);
    qrx_in   = DW'(q);
    tick();
  endtask

  task automatic preamble(input int np, input int nn);
    for (int k = 0; k < np; k++) smp(1'b1, 16384, 5);
    for (int k = 0; k < nn; k++) smp(1'b1, -16384, -5);
  endtask

  task automatic do_clear();
    clear    = 1'b1;
    in_valid = 1'b0;
    tick();
    clear   = 1'b0;
    err_cnt = 0;
    fd_cnt  = 0;
    got.delete();
  endtask

  // Full frame at tready=1, optionally with an ignored invalid cycle after every sample.
  task automatic run_frame(input string nm, input bit gaps, input int di, input int dq);
    res_t exp_tbl[3];
    for (int k = 0; k < 3; k++) begin
      exp_tbl[k].i    = 4 * longint'(di);
      exp_tbl[k].q    = 4 * longint'(dq);
      exp_tbl[k].symb = k;
      exp_tbl[k].last = (k == 2) ? 1 : 0;
    end
    got.delete();
    fd_cnt     = 0;
    out_tready = 1'b1;
    preamble(16, 16);
    for (int n = 0; n < 12; n++) begin
      smp(1'b1, di, dq);
      if (n == 2) check({nm, "_tvalid_before_dump"}, longint'(out_tvalid), 0);
      if (n == 3) begin
        check({nm, "_latency_tvalid"}, longint'(out_tvalid), 1);
        check({nm, "_latency_symb"}, longint'(out_symb), 0);
      end
      if (n == 11) begin
        check({nm, "_frame_done"}, longint'(frame_done), 1);
        check({nm, "_tlast"}, longint'(out_tlast), 1);
        check({nm, "_state_end"}, longint'(state), 0);
        check({nm, "_locked_end"}, longint'(sync_locked), 0);
      end
      if (gaps) smp(1'b0, 16384, 777);
    end
    smp(1'b0, 0, 0);
    smp(1'b0, 0, 0);
    check({nm, "_tvalid_drained"}, longint'(out_tvalid), 0);
    check({nm, "_result_count"}, longint'(got.size()), 3);
    check({nm, "_frame_done_count"}, longint'(fd_cnt), 1);
    for (int k = 0; k < 3 && k < got.size(); k++) begin
      check($sformatf("%s_i%0d", nm, k), got[k].i, exp_tbl[k].i);
      check($sformatf("%s_q%0d", nm, k), got[k].q, exp_tbl[k].q);
      check($sformatf("%s_symb%0d", nm, k), longint'(got[k].symb), longint'(exp_tbl[k].symb));
      check($sformatf("%s_last%0d", nm, k), longint'(got[k].last), longint'(exp_tbl[k].last));
    end
  endtask

  initial begin
    sync_vec_t sv[12];
    sv[0]  = '{10, 1, 0, 0,      0, 0, 1};
    sv[1]  = '{16, 8, 1, 0,      0, 0, 1};
    sv[2]  = '{16, 16, 0, 0,     3, 1, 0};
    sv[3]  = '{12, 16, 0, 0,     3, 1, 0};
    sv[4]  = '{11, 1, 0, 0,      0, 0, 1};
    sv[5]  = '{20, 1, 0, 0,      0, 0, 1};
    sv[6]  = '{16, 15, 0, 0,     2, 0, 0};
    sv[7]  = '{16, 15, 1, -8192, 3, 1, 0};
    sv[8]  = '{5, 0, 1, 8191,    0, 0, 1};
    sv[9]  = '{0, 0, 1, 8192,    1, 0, 0};
    sv[10] = '{0, 0, 1, -16384,  0, 0, 0};
    sv[11] = '{13, 0, 1, -8191,  0, 0, 1};

    reset      = 1'b1;
    clear      = 1'b0;
    in_valid   = 1'b0;
    out_tready = 1'b0;
    irx_in     = '0;
    qrx_in     = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_state", longint'(state), 0);
    check("reset_tvalid", longint'(out_tvalid), 0);
    check("reset_out_i", longint'($signed(out_i)), 0);
    check("reset_out_q", longint'($signed(out_q)), 0);
    check("reset_locked", longint'(sync_locked), 0);
    check("reset_overflow", longint'(overflow), 0);
    check("reset_symb", longint'(out_symb), 0);

    // Preamble acceptance/rejection table, one invalid garbage cycle mid-sequence.
    for (int r = 0; r < 12; r++) begin
      do_clear();
      for (int k = 0; k < sv[r].np; k++) smp(1'b1, 16384, 3);
      smp(1'b0, 0, 0);
      for (int k = 0; k < sv[r].nn; k++) smp(1'b1, -16384, 3);
      if (sv[r].tail != 0) smp(1'b1, sv[r].tail_i, 0);
      smp(1'b0, 0, 0);
      check($sformatf("sync%0d_state", r), longint'(state), longint'(sv[r].exp_state));
      check($sformatf("sync%0d_locked", r), longint'(sync_locked), longint'(sv[r].exp_lock));
      check($sformatf("sync%0d_err", r), longint'(err_cnt), longint'(sv[r].exp_err));
      check($sformatf("sync%0d_tvalid", r), longint'(out_tvalid), 0);
    end

    do_clear();
    run_frame("clean", 1'b0, 100, -50);
    do_clear();
    run_frame("gaps", 1'b1, 100, -50);

    // Backpressure across symbols 0 and 1, then accept on the symbol-2 dump cycle.
    do_clear();
    out_tready = 1'b0;
    preamble(16, 16);
    for (int n = 0; n < 8; n++) smp(1'b1, 100, -50);
    check("bp_overflow", longint'(overflow), 1);
    check("bp_tvalid", longint'(out_tvalid), 1);
    check("bp_symb", longint'(out_symb), 1);
    check("bp_out_i", longint'($signed(out_i)), 400);
    for (int n = 0; n < 3; n++) smp(1'b1, 100, -50);
    check("bp_hold_tvalid", longint'(out_tvalid), 1);
    check("bp_hold_symb", longint'(out_symb), 1);
    out_tready = 1'b1;
    smp(1'b1, 100, -50);
    check("bp_acc_dump_tvalid", longint'(out_tvalid), 1);
    check("bp_acc_dump_symb", longint'(out_symb), 2);
    check("bp_acc_dump_tlast", longint'(out_tlast), 1);
    check("bp_overflow_sticky", longint'(overflow), 1);
    check("bp_accepted_symb1", longint'(got.size() > 0 ? got[0].symb : -1), 1);
    smp(1'b0, 0, 0);
    check("bp_tvalid_drop", longint'(out_tvalid), 0);

    // Accept coinciding with the next dump must not flag overflow.
    do_clear();
    out_tready = 1'b0;
    preamble(16, 16);
    for (int n = 0; n < 7; n++) smp(1'b1, 100, -50);
    check("bp2_pending_symb", longint'(out_symb), 0);
    out_tready = 1'b1;
    smp(1'b1, 100, -50);
    check("bp2_tvalid", longint'(out_tvalid), 1);
    check("bp2_symb", longint'(out_symb), 1);
    check("bp2_no_overflow", longint'(overflow), 0);

    // Clear in symbol 1 with a valid sample present, then a fresh frame.
    do_clear();
    out_tready = 1'b0;
    preamble(16, 16);
    for (int n = 0; n < 5; n++) smp(1'b1, 100, -50);
    check("abort_pre_state", longint'(state), 3);
    check("abort_pre_tvalid", longint'(out_tvalid), 1);
    clear = 1'b1;
    smp(1'b1, 16384, 9);
    clear = 1'b0;
    check("abort_state", longint'(state), 0);
    check("abort_tvalid", longint'(out_tvalid), 0);
    check("abort_out_i", longint'($signed(out_i)), 0);
    check("abort_out_q", longint'($signed(out_q)), 0);
    check("abort_symb", longint'(out_symb), 0);
    check("abort_locked", longint'(sync_locked), 0);
    check("abort_overflow", longint'(overflow), 0);
    check("abort_tlast", longint'(out_tlast), 0);
    run_frame("refrm", 1'b0, -20000, 32767);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
